// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the program loader and the core.
// The core is held in BOOT until the load completes; afterwards loader and core are arbitrated round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 13,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_ack,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_run,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is held high until its ack; the ack is a one-cycle
  // pulse in the cycle the access completes (write strobe, or read data valid).

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_IDLE    = 2'd1,
    S_WR      = 2'd2,
    S_RD_WAIT = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              rr_cpu_q, rr_cpu_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              run_q, run_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_req;
  logic              grant_ld;
  logic              grant_cpu;

  assign cpu_req   = cpu_read | cpu_write;
  assign cpu_run   = run_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_BOOT;
      rr_cpu_q <= 1'b1;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_cpu_q <= rr_cpu_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_cpu_d  = rr_cpu_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    rdata_d   = rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_ack    = 1'b0;
    cpu_ack   = 1'b0;
    cpu_rdata = rdata_q;
    grant_ld  = 1'b0;
    grant_cpu = 1'b0;

    case (state_q)
      S_BOOT: begin
        if (ld_req) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_wdata;
          ld_ack    = 1'b1;
        end
        if (ld_done) begin
          run_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        // rr_cpu_q set means the core was served last, so the loader wins a tie.
        grant_ld  = ld_req && (!cpu_req || rr_cpu_q);
        grant_cpu = cpu_req && !grant_ld;
        if (grant_ld) begin
          rr_cpu_d  = 1'b0;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_wdata;
          ld_ack    = 1'b1;
        end else if (grant_cpu) begin
          rr_cpu_d = 1'b1;
          mem_en   = 1'b1;
          mem_addr = cpu_addr;
          if (cpu_read) begin
            state_d = S_RD_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = cpu_wdata;
            cpu_ack   = 1'b1;
          end
        end
      end

      S_RD_WAIT: begin
        // Data is passed straight through on the valid cycle and held afterwards.
        if (cnt_q == 3'd0) begin
          cpu_ack   = 1'b1;
          cpu_rdata = mem_rdata;
          rdata_d   = mem_rdata;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A reset cycle must not strobe memory or ack an access that is being aborted.
    if (reset) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ld_ack    = 1'b0;
      cpu_ack   = 1'b0;
      cpu_rdata = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model with read pipeline, strobe/ack scoreboard.
module tb_mem_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 13;
  localparam int RD_LAT = 2;

  logic          clk;
  logic          reset;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_done;
  logic          ld_ack;
  logic          cpu_read;
  logic          cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_run;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done), .ld_ack(ld_ack),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_run(cpu_run),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] pipe [0:RD_LAT-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[5] = 13'h1F3;
    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem[mem_addr];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [27:0] exp_q[$];   // {from_loader, we, addr, wdata}
  logic [44:0] rd_q[$];    // {ack_cycle, rdata}
  logic [27:0] e_s;
  logic [44:0] e_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_strobe(input logic ld, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({ld, we, a, d});
  endtask

  task automatic push_read(input int ack_cyc, input logic [DW-1:0] d);
    rd_q.push_back({32'(ack_cyc), d});
  endtask

  always @(negedge clk) begin
    if (mem_en) begin
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", 32'(mem_en), 32'd0);
      end else begin
        e_s = exp_q.pop_front();
        chk("mem_we", 32'(mem_we), 32'(e_s[26]));
        chk("mem_addr", 32'(mem_addr), 32'(e_s[25:13]));
        if (e_s[26]) begin
          chk("mem_wdata", 32'(mem_wdata), 32'(e_s[12:0]));
          chk("cpu_wr_ack", 32'(cpu_ack), 32'(!e_s[27]));
        end else begin
          chk("rd_strobe_no_ack", 32'(cpu_ack), 32'd0);
        end
        chk("ld_ack", 32'(ld_ack), 32'(e_s[27]));
      end
    end else if (ld_ack) begin
      chk("ld_ack_without_strobe", 32'(ld_ack), 32'd0);
    end
    if (cpu_ack && !mem_en) begin
      if (rd_q.size() == 0) begin
        chk("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
      end else begin
        e_r = rd_q.pop_front();
        chk("rd_latency", 32'(cyc), e_r[44:13]);
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e_r[12:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu_ack(input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
    cpu_read = 1'b1;
    cpu_addr = a;
    push_strobe(1'b0, 1'b0, a, '0);
    push_read(cyc + RD_LAT, exp_d);
    wait_cpu_ack("cpu_rd");
    cpu_read = 1'b0;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_write = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    push_strobe(1'b0, 1'b1, a, d);
    wait_cpu_ack("cpu_wr");
    cpu_write = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] order;
  logic       win_ld;
  logic       rr_cpu_m;
  int         li, ci;

  initial begin
    reset = 1'b1; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    tick();
    reset = 1'b0;

    // Boot load with the core requesting a read the whole time
    cpu_read = 1'b1;
    cpu_addr = 13'd2;
    for (int i = 0; i < 4; i++) begin
      ld_req   = 1'b1;
      ld_addr  = 13'(i);
      ld_wdata = 13'h0A1 + 13'(i);
      push_strobe(1'b1, 1'b1, ld_addr, ld_wdata);
      tick();
    end
    ld_req  = 1'b0;
    ld_done = 1'b1;
    @(negedge clk);
    chk("boot_run_before", 32'(cpu_run), 32'd0);
    tick();
    ld_done = 1'b0;
    push_strobe(1'b0, 1'b0, 13'd2, '0);
    push_read(cyc + RD_LAT, 13'h0A3);
    @(negedge clk);
    chk("boot_run_after", 32'(cpu_run), 32'd1);
    wait_cpu_ack("boot_rd");
    cpu_read = 1'b0;

    // Read latency and write/read-back
    cpu_rd(13'd5, 13'h1F3);
    cpu_wr(13'd9, 13'h155);
    cpu_rd(13'd9, 13'h155);

    // Read and write together: the read wins, the write is dropped
    cpu_write = 1'b1;
    cpu_wdata = 13'h777;
    cpu_rd(13'd5, 13'h1F3);
    cpu_write = 1'b0;

    // Contention: the last grant went to the core, so the loader goes first
    rr_cpu_m = 1'b1;
    li = 0;
    ci = 0;
    order = '0;
    for (int g = 0; g < 4; g++) begin
      ld_req    = 1'b1;
      ld_addr   = 13'h100 + 13'(li);
      ld_wdata  = 13'h0C0 + 13'(li);
      cpu_write = 1'b1;
      cpu_addr  = 13'h200 + 13'(ci);
      cpu_wdata = 13'h0D0 + 13'(ci);
      win_ld = rr_cpu_m;
      if (win_ld) push_strobe(1'b1, 1'b1, ld_addr, ld_wdata);
      else        push_strobe(1'b0, 1'b1, cpu_addr, cpu_wdata);
      @(negedge clk);
      order = {order[2:0], ld_ack};
      tick();
      if (win_ld) li++;
      else        ci++;
      rr_cpu_m = !win_ld;
    end
    ld_req    = 1'b0;
    cpu_write = 1'b0;
    chk("rr_order", 32'(order), 32'b1010);
    cpu_rd(13'h101, 13'h0C1);
    cpu_rd(13'h201, 13'h0D1);

    // Loader request arriving while a read is outstanding
    cpu_read = 1'b1;
    cpu_addr = 13'd5;
    push_strobe(1'b0, 1'b0, 13'd5, '0);
    push_read(cyc + RD_LAT, 13'h1F3);
    tick();
    ld_req   = 1'b1;
    ld_addr  = 13'h300;
    ld_wdata = 13'h0BB;
    wait_cpu_ack("ld_during_rd");
    cpu_read = 1'b0;
    push_strobe(1'b1, 1'b1, 13'h300, 13'h0BB);
    @(negedge clk);
    chk("ld_after_ack", 32'(ld_ack), 32'd1);
    tick();
    ld_req = 1'b0;

    // ld_done outside BOOT is ignored
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    @(negedge clk);
    chk("late_done_run", 32'(cpu_run), 32'd1);
    chk("late_done_state", 32'(dbg_state), 32'd1);
    tick();

    // Reset in the middle of a read
    cpu_read = 1'b1;
    cpu_addr = 13'd5;
    push_strobe(1'b0, 1'b0, 13'd5, '0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", 32'(cpu_ack), 32'd0);
    chk("rst_mid_en", 32'(mem_en), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_run", 32'(cpu_run), 32'd0);
    chk("post_rst_state", 32'(dbg_state), 32'd0);
    chk("post_rst_rdata", 32'(cpu_rdata), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("boot_ignores_cpu", 32'({mem_en, cpu_ack}), 32'd0);
    end
    tick();
    cpu_read = 1'b0;

    // Simultaneous loader write and ld_done at the top address
    ld_req   = 1'b1;
    ld_addr  = 13'h1FFF;
    ld_wdata = 13'h1AB;
    ld_done  = 1'b1;
    push_strobe(1'b1, 1'b1, 13'h1FFF, 13'h1AB);
    @(negedge clk);
    chk("simul_run_before", 32'(cpu_run), 32'd0);
    tick();
    ld_req  = 1'b0;
    ld_done = 1'b0;
    @(negedge clk);
    chk("simul_run_after", 32'(cpu_run), 32'd1);
    chk("simul_state", 32'(dbg_state), 32'd1);
    tick();
    cpu_rd(13'h1FFF, 13'h1AB);
    chk("rdata_hold", 32'(cpu_rdata), 32'h1AB);

    // Random reads of locations written above
    for (int i = 0; i < 6; i++) begin
      int k;
      k = $urandom_range(0, 3);
      cpu_rd(13'(k), 13'h0A1 + 13'(k));
    end

    tick(); tick(); tick();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
